// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port RAM between a CPU and a host.
//   clock, reset             : single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU access request; we/addr/wdata sampled at grant
//   cpu_ack, cpu_rdata       : one-cycle completion pulse, read data valid with ack
//   host_*                   : same as cpu_* for the loader/debug host
//   ram_cs/we/addr/wdata     : RAM command, active for exactly one cycle per access
//   ram_rdata                : RAM read data, captured at the end of a read access
//   owner                    : 01 cpu, 10 host while the RAM is being accessed, else 00
module ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        owner
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state_q, state_d;
    // Updated at every grant, so during ACC/DONE it also names the current winner.
    logic last_host_q, last_host_d;
    logic ram_cs_q, ram_cs_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic cpu_ack_q, cpu_ack_d, host_ack_q, host_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;
    logic [1:0] owner_q, owner_d;
    logic grant, pick_host, in_acc;

    always_comb begin
        in_acc       = state_q == ACC;
        // A tie goes to whoever was not served last.
        pick_host    = host_req & (~cpu_req | ~last_host_q);
        grant        = (cpu_req | host_req) & ~in_acc;
        state_d      = grant ? ACC : (in_acc ? DONE : IDLE);
        last_host_d  = grant ? pick_host : last_host_q;
        ram_cs_d     = grant;
        ram_we_d     = grant & (pick_host ? host_we : cpu_we);
        ram_addr_d   = grant ? (pick_host ? host_addr : cpu_addr) : ram_addr_q;
        ram_wdata_d  = grant ? (pick_host ? host_wdata : cpu_wdata) : ram_wdata_q;
        owner_d      = grant ? (pick_host ? 2'b10 : 2'b01) : 2'b00;
        cpu_ack_d    = in_acc & ~last_host_q;
        host_ack_d   = in_acc & last_host_q;
        // Writes leave the previously returned read data in place.
        cpu_rdata_d  = (cpu_ack_d & ~ram_we_q) ? ram_rdata : cpu_rdata_q;
        host_rdata_d = (host_ack_d & ~ram_we_q) ? ram_rdata : host_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_host_q  <= 1'b1;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            owner_q      <= 2'b00;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_host_q  <= last_host_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            owner_q      <= owner_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign ram_cs     = ram_cs_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign owner      = owner_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
endmodule
